count_bcd_display: RTL

- Downstream stage of the 7-bit run/reset counter.
- Takes the counter's 7-bit binary value (0..127) and converts it to three BCD digits using a sequential shift-add-3 (double-dabble) FSM.
- Drives a 4-digit common-anode multiplexed seven-segment display, with leading-zero blanking.
- Sits between the counter output and the board display pins.

---
 rtl/count_bcd_display.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/count_bcd_display.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a 4-digit
// common-anode multiplexed seven-segment display with leading-zero blanking.
module count_bcd_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [6:0]  count_in,
  input  logic        load,
  output logic        busy,
  output logic [11:0] bcd_out,
  output logic        bcd_valid,
  output logic [6:0]  seg_n,
  output logic [3:0]  an_n,
  output logic        dp_n
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_q;
  logic [18:0] shift_q;
  logic [18:0] adj_d;
  logic [18:0] shift_d;
  logic [2:0]  iter_q;
  logic [11:0] bcd_q;
  logic        valid_q;
  logic        busy_q;

  // Add-3 correction on every BCD nibble above the 7-bit binary field.
  assign adj_d[6:0] = shift_q[6:0];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adj
      logic [3:0] nib;
      assign nib = shift_q[7 + 4*gi +: 4];
      assign adj_d[7 + 4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
  endgenerate

  assign shift_d = adj_d << 1;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      iter_q  <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load) begin
            shift_q <= {12'b0, count_in};
            iter_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          shift_q <= shift_d;
          iter_q  <= iter_q + 3'd1;
          if (iter_q == 3'd6) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          bcd_q   <= shift_q[18:7];
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign bcd_out   = bcd_q;
  assign bcd_valid = valid_q;

  logic [RW-1:0] refresh_q;
  logic [1:0]    digit_q;
  logic          tick;
  logic [3:0]    nib_sel;
  logic [3:0]    an_d;
  logic [6:0]    seg_d;
  logic [3:0]    an_q;
  logic [6:0]    seg_q;

  assign tick = (refresh_q == RW'(REFRESH_DIV - 1));

  // Slot select; a blanked slot maps to an out-of-range nibble, which decodes to all-off.
  always_comb begin
    nib_sel = 4'hF;
    an_d    = 4'b1111;
    case (digit_q)
      2'd0: begin
        nib_sel = bcd_q[3:0];
        an_d    = 4'b1110;
      end
      2'd1: begin
        if (bcd_q[11:4] != 8'd0) begin
          nib_sel = bcd_q[7:4];
          an_d    = 4'b1101;
        end
      end
      2'd2: begin
        if (bcd_q[11:8] != 4'd0) begin
          nib_sel = bcd_q[11:8];
          an_d    = 4'b1011;
        end
      end
      default: begin
        nib_sel = 4'hF;
        an_d    = 4'b1111;
      end
    endcase
  end

  always_comb begin
    case (nib_sel)
      4'd0:    seg_d = 7'h40;
      4'd1:    seg_d = 7'h79;
      4'd2:    seg_d = 7'h24;
      4'd3:    seg_d = 7'h30;
      4'd4:    seg_d = 7'h19;
      4'd5:    seg_d = 7'h12;
      4'd6:    seg_d = 7'h02;
      4'd7:    seg_d = 7'h78;
      4'd8:    seg_d = 7'h00;
      4'd9:    seg_d = 7'h10;
      default: seg_d = 7'h7F;
    endcase
  end

  // The current slot is latched on the tick, then the index moves on.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      refresh_q <= '0;
      digit_q   <= '0;
      an_q      <= 4'b1111;
      seg_q     <= 7'h7F;
    end else begin
      if (tick) begin
        refresh_q <= '0;
        digit_q   <= digit_q + 2'd1;
        an_q      <= an_d;
        seg_q     <= seg_d;
      end else begin
        refresh_q <= refresh_q + RW'(1);
      end
    end
  end

  assign an_n  = an_q;
  assign seg_n = seg_q;
  assign dp_n  = 1'b1;

endmodule
